// File: rtl/fp_mul_sequencer.sv
// Operand FIFO plus one-pair-at-a-time sequencer driving the FP multiplier St/Done handshake
// and presenting each product (or a timeout error) on a valid/ready result stream.
module fp_mul_sequencer #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned Settle  = 2,
  parameter int unsigned Timeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_prod_o,
  output logic        out_ovf_o,
  output logic        out_unf_o,
  output logic        out_err_o,
  output logic        mul_st_o,
  output logic [31:0] mul_fpmplier_o,
  output logic [31:0] mul_fpmcand_o,
  input  logic        mul_done_i,
  input  logic        mul_ovf_i,
  input  logic        mul_unf_i,
  input  logic [31:0] mul_fpproduct_i,
  output logic        busy_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DoneW = $clog2(Settle + 1);
  localparam int unsigned TimeW = $clog2(Timeout + 1);

  typedef enum logic [2:0] {StIdle, StStart, StWaitDone, StRelease, StOutput} state_e;

  state_e            state_q, state_d;
  logic [63:0]       fifo_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [DoneW-1:0]  done_cnt_q, done_cnt_d;
  logic [TimeW-1:0]  to_cnt_q, to_cnt_d;
  logic              push, pop, capture, abort;

  assign in_ready_o = (count_q != CntW'(Depth));
  assign push       = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != StIdle) || (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    done_cnt_d  = done_cnt_q;
    to_cnt_d    = to_cnt_q;
    pop         = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    mul_st_o    = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && !mul_done_i) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        mul_st_o   = 1'b1;
        done_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        mul_st_o   = 1'b1;
        done_cnt_d = mul_done_i ? done_cnt_q + DoneW'(1) : '0;
        to_cnt_d   = to_cnt_q + TimeW'(1);
        // Flags lag Done by a cycle, so only capture after Settle consecutive Done cycles.
        if (done_cnt_d == DoneW'(Settle)) begin
          capture = 1'b1;
          state_d = StRelease;
        end else if (to_cnt_d == TimeW'(Timeout)) begin
          abort   = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!mul_done_i) state_d = StOutput;
      end
      StOutput: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {in_a_i, in_b_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      done_cnt_q     <= '0;
      to_cnt_q       <= '0;
      mul_fpmplier_o <= '0;
      mul_fpmcand_o  <= '0;
      out_prod_o     <= '0;
      out_ovf_o      <= 1'b0;
      out_unf_o      <= 1'b0;
      out_err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
      to_cnt_q   <= to_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q                          <= rd_ptr_q + PtrW'(1);
        {mul_fpmplier_o, mul_fpmcand_o}   <= fifo_q[rd_ptr_q];
      end
      if (capture) begin
        out_prod_o <= mul_fpproduct_i;
        out_ovf_o  <= mul_ovf_i;
        out_unf_o  <= mul_unf_i;
        out_err_o  <= 1'b0;
      end else if (abort) begin
        out_prod_o <= '0;
        out_ovf_o  <= 1'b0;
        out_unf_o  <= 1'b0;
        out_err_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Bench for fp_mul_sequencer: behavioural multiplier stub, queue scoreboard and directed plus
// randomized operand streams.
module tb_fp_mul_sequencer;

  localparam int Depth   = 4;
  localparam int Timeout = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_a_i, in_b_i, out_prod_o, mul_fpmplier_o, mul_fpmcand_o, mul_fpproduct_i;
  logic        out_ovf_o, out_unf_o, out_err_o, mul_st_o, busy_o;
  logic        mul_done_i, mul_ovf_i, mul_unf_i;

  fp_mul_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_prod_o(out_prod_o),
    .out_ovf_o(out_ovf_o), .out_unf_o(out_unf_o), .out_err_o(out_err_o),
    .mul_st_o(mul_st_o), .mul_fpmplier_o(mul_fpmplier_o), .mul_fpmcand_o(mul_fpmcand_o),
    .mul_done_i(mul_done_i), .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i),
    .mul_fpproduct_i(mul_fpproduct_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single-precision multiply, truncating; returns {ovf, unf, product}.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] ma, mb, p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  // Multiplier stub: Done three cycles after St rises, flags one cycle after Done.
  logic        kill;
  int          stub_cnt;
  logic [33:0] stub_r;
  assign stub_r = fmul(mul_fpmplier_o, mul_fpmcand_o);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stub_cnt <= 0; mul_done_i <= 1'b0; mul_ovf_i <= 1'b0; mul_unf_i <= 1'b0;
      mul_fpproduct_i <= 32'd0;
    end else if (mul_st_o) begin
      stub_cnt        <= stub_cnt + 1;
      mul_done_i      <= (stub_cnt >= 2) && !kill;
      mul_fpproduct_i <= stub_r[31:0];
      mul_ovf_i       <= mul_done_i && stub_r[33];
      mul_unf_i       <= mul_done_i && stub_r[32];
    end else begin
      stub_cnt <= 0; mul_done_i <= 1'b0; mul_ovf_i <= 1'b0; mul_unf_i <= 1'b0;
    end
  end

  // Scoreboard state: expected results in push order, {err, ovf, unf, prod}.
  logic [34:0] exp_q[$];
  logic [34:0] exp_v, prev_out;
  int          outstanding = 0, n_out = 0, valid_rises = 0, st_run = 0;
  logic        st_kill, prev_valid = 1'b0, prev_ready = 1'b0, valid_seen = 1'b0;
  logic [31:0] last_prod;
  logic        last_ovf, last_unf, last_err;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      outstanding = 0; st_run = 0; prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      check("busy", busy_o, outstanding != 0);
      if (outstanding < Depth) check("in_ready_free", in_ready_o, 1);
      if (outstanding == Depth + 1) check("in_ready_full", in_ready_o, 0);
      if (mul_st_o) check("st_vs_valid", out_valid_o, 0);
      if (prev_valid && !prev_ready)
        check("hold", {out_valid_o, out_err_o, out_ovf_o, out_unf_o, out_prod_o},
              {1'b1, prev_out});
      if (mul_st_o) begin
        if (st_run == 0) st_kill = kill;
        st_run++;
      end else if (st_run != 0) begin
        check("st_len", st_run, st_kill ? Timeout + 1 : 5);
        st_run = 0;
      end
      if (out_valid_o) valid_seen = 1'b1;
      if (out_valid_o && !prev_valid) valid_rises++;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", {out_err_o, out_ovf_o, out_unf_o, out_prod_o}, exp_v);
          outstanding--;
        end
        n_out++;
        last_prod = out_prod_o; last_ovf = out_ovf_o; last_unf = out_unf_o;
        last_err  = out_err_o;
      end
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(kill ? {1'b1, 34'd0} : {1'b0, fmul(in_a_i, in_b_i)});
        outstanding++;
      end
      prev_valid = out_valid_o;
      prev_ready = out_ready_i;
      prev_out   = {out_err_o, out_ovf_o, out_unf_o, out_prod_o};
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   guard = 0;
    in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
    do begin
      @(negedge clk_i); acc = in_ready_o;
      @(posedge clk_i); #1; guard++;
    end while (!acc && guard < 500);
    in_valid_i = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((outstanding != 0 || busy_o) && guard < 2000) begin cyc(1); guard++; end
    if (guard >= 2000) check("drain_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    e = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  int base, base_r;
  logic rnd_done;

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; out_ready_i = 1'b1; kill = 1'b0;
    cyc(3);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_mul_st", mul_st_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_outs", {out_err_o, out_ovf_o, out_unf_o, out_prod_o}, 0);
    check("rst_operands", {mul_fpmplier_o, mul_fpmcand_o}, 0);
    rst_i = 1'b0;
    cyc(2);

    check("model_basic", fmul(32'h40400000, 32'h40000000), {2'b00, 32'h40C00000});
    check("model_ovf", fmul(32'h7F000000, 32'h7F000000), {2'b10, 32'h7F800000});
    check("model_unf", fmul(32'h00800000, 32'h00800000), {2'b01, 32'h00000000});

    // Basic product
    base = n_out;
    push(32'h40400000, 32'h40000000);
    drain();
    check("c1_count", n_out - base, 1);
    check("c1_prod", last_prod, 32'h40C00000);
    check("c1_flags", {last_err, last_ovf, last_unf}, 3'b000);
    check("c1_st_low", mul_st_o, 0);

    // Overflow
    base = n_out; base_r = valid_rises;
    push(32'h7F000000, 32'h7F000000);
    drain();
    check("c2_ovf_unf", {last_ovf, last_unf}, 2'b10);
    check("c2_once", n_out - base, 1);
    check("c2_valid_rises", valid_rises - base_r, 1);

    // Underflow
    push(32'h00800000, 32'h00800000);
    drain();
    check("c3_ovf_unf", {last_ovf, last_unf}, 2'b01);

    // Backpressure: one pair in flight, four queued, sixth must wait
    base = n_out;
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h3F800000 + (i << 23), 32'h40000000 + i);
    cyc(10);
    check("c4_in_ready_full", in_ready_o, 0);
    check("c4_out_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    push(32'h41000000, 32'h41000000);
    drain();
    check("c4_count", n_out - base, 6);

    // Timeout
    kill = 1'b1;
    push(32'h40400000, 32'h40400000);
    drain();
    check("c5_err", last_err, 1);
    check("c5_prod", {last_prod, last_ovf, last_unf}, 0);
    check("c5_idle", busy_o, 0);

    // Reset in WAIT_DONE with two pairs queued
    for (int i = 0; i < 3; i++) push(32'h40000000, 32'h40000000);
    cyc(3);
    check("c6_waiting", {mul_st_o, busy_o}, 2'b11);
    rst_i = 1'b1;
    #1;
    check("c6_rst_st", mul_st_o, 0);
    check("c6_rst_valid", out_valid_o, 0);
    check("c6_rst_ready", in_ready_o, 1);
    cyc(2);
    kill = 1'b0;
    rst_i = 1'b0;
    valid_seen = 1'b0;
    cyc(30);
    check("c6_no_stale", valid_seen, 0);

    // Randomized traffic with random backpressure
    base = n_out; rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          cyc($urandom_range(0, 3));
          push(rand_op(), rand_op());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          cyc(1);
          out_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_i = 1'b1;
    drain();
    check("rand_count", n_out - base, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
